// File: rtl/tap_serializer_pkg.sv
// Shared definitions for the tap-line serializer and the tap shift register.
// Contents:
//   DefaultWidth / DefaultDepth - frame geometry shared with the tap shift register
//   ts_state_e                  - serializer FSM state encoding
//   idx_width()                 - width of a word index for a given frame depth
package tap_serializer_pkg;

  localparam int unsigned DefaultWidth = 24;
  localparam int unsigned DefaultDepth = 29;

  typedef enum logic [0:0] {
    TsIdle = 1'b0,
    TsSend = 1'b1
  } ts_state_e;

  // Index width for a frame of 'depth' words; at least one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tap_serializer_frame_word_select.sv
// Combinational word mux: picks word 'index' out of a packed frame.
// Ports:
//   frame_i - DEPTH words of WIDTH bits, word k at [WIDTH*k +: WIDTH]
//   index_i - word index
//   word_o  - selected word; zero if index_i is out of range
module tap_serializer_frame_word_select import tap_serializer_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned IdxW = idx_width(DEPTH)
) (
  input  logic [WIDTH*DEPTH-1:0] frame_i,
  input  logic [IdxW-1:0]        index_i,
  output logic [WIDTH-1:0]       word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (index_i == IdxW'(k)) begin
        word_o = frame_i[WIDTH*k +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/tap_serializer.sv
// Parallel-in / serial-out frame unloader (mirror of the FIR tap line).
// Captures a DEPTH-word frame on a load handshake, then emits it one word per
// accepted beat. A new frame can be taken on the final beat, so back-to-back
// frames stream without bubbles.
// Ports:
//   clk, reset_n             - clock, async active-low reset
//   load_valid / load_ready  - frame load handshake, frame on parallel_in
//   out_valid / out_ready    - output stream handshake
//   serial_out               - current word (zero while idle)
//   out_last                 - current word is the frame's final word
//   out_index                - frame index of current word (zero while idle)
module tap_serializer import tap_serializer_pkg::*; #(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter bit          OLDEST_1ST = 1'b1,
  localparam int unsigned IdxW      = idx_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WIDTH*DEPTH-1:0] parallel_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       serial_out,
  output logic                   out_last,
  output logic [IdxW-1:0]        out_index
);

  localparam logic [IdxW-1:0] LastCount = IdxW'(DEPTH - 1);

  ts_state_e              state_q, state_d;
  logic [WIDTH*DEPTH-1:0] frame_q, frame_d;
  logic [IdxW-1:0]        count_q, count_d;

  logic            sending, at_last, load_fire, beat_fire;
  logic [IdxW-1:0] word_idx;
  logic [WIDTH-1:0] word;

  assign sending   = (state_q == TsSend);
  assign at_last   = sending & (count_q == LastCount);
  // reset_n gates load_ready so nothing upstream sees a handshake during reset.
  assign load_ready = reset_n & (~sending | (at_last & out_ready));
  assign load_fire  = load_valid & load_ready;
  assign beat_fire  = sending & out_ready;
  assign word_idx   = OLDEST_1ST ? (LastCount - count_q) : count_q;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    count_d = count_q;
    unique case (state_q)
      TsIdle: begin
        if (load_fire) begin
          frame_d = parallel_in;
          count_d = '0;
          state_d = TsSend;
        end
      end
      TsSend: begin
        if (beat_fire) begin
          if (at_last) begin
            count_d = '0;
            if (load_fire) begin
              frame_d = parallel_in;
            end else begin
              state_d = TsIdle;
            end
          end else begin
            count_d = count_q + IdxW'(1);
          end
        end
      end
      default: state_d = TsIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TsIdle;
      frame_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      count_q <= count_d;
    end
  end

  tap_serializer_frame_word_select #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_word_select (
    .frame_i (frame_q),
    .index_i (word_idx),
    .word_o  (word)
  );

  // Outputs are zeroed outside SEND so idle/reset values are clean and defined.
  assign out_valid  = sending;
  assign out_last   = at_last;
  assign out_index  = sending ? word_idx : '0;
  assign serial_out = sending ? word : '0;

endmodule

// File: tb/tb_tap_serializer.sv
// Directed bench: table of per-cycle vectors for a DEPTH=4 oldest-first
// instance, plus hand sequences for async reset mid-frame and a DEPTH=3
// index-order instance.
module tb_tap_serializer;

  localparam logic [31:0] F1 = 32'h4433_2211;
  localparam logic [31:0] F2 = 32'hDDCC_BBAA;

  typedef struct {
    logic        lv;
    logic        ordy;
    logic [31:0] pin;
    logic        lr;
    logic        ov;
    logic [7:0]  so;
    logic        last;
    logic [1:0]  idx;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;

  logic        a_lv, a_lr, a_ov, a_ordy, a_last;
  logic [31:0] a_pin;
  logic [7:0]  a_so;
  logic [1:0]  a_idx;

  logic        b_lv, b_lr, b_ov, b_ordy, b_last;
  logic [23:0] b_pin;
  logic [7:0]  b_so;
  logic [1:0]  b_idx;

  int n_vec = 0;
  int n_bad = 0;

  vec_t vecs[31];

  always #5 clk = ~clk;

  tap_serializer #(
    .WIDTH      (8),
    .DEPTH      (4),
    .OLDEST_1ST (1'b1)
  ) u_dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_valid  (a_lv),
    .load_ready  (a_lr),
    .parallel_in (a_pin),
    .out_valid   (a_ov),
    .out_ready   (a_ordy),
    .serial_out  (a_so),
    .out_last    (a_last),
    .out_index   (a_idx)
  );

  tap_serializer #(
    .WIDTH      (8),
    .DEPTH      (3),
    .OLDEST_1ST (1'b0)
  ) u_dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_valid  (b_lv),
    .load_ready  (b_lr),
    .parallel_in (b_pin),
    .out_valid   (b_ov),
    .out_ready   (b_ordy),
    .serial_out  (b_so),
    .out_last    (b_last),
    .out_index   (b_idx)
  );

  function automatic vec_t mk(input logic lv, input logic ordy, input logic [31:0] pin,
                              input logic lr, input logic ov, input logic [7:0] so,
                              input logic last, input logic [1:0] idx);
    vec_t v;
    v.lv = lv; v.ordy = ordy; v.pin = pin;
    v.lr = lr; v.ov = ov; v.so = so; v.last = last; v.idx = idx;
    return v;
  endfunction

  // Packed view {lr, ov, so, last, idx}.
  function automatic logic [15:0] pk(input logic lr, input logic ov, input logic [7:0] so,
                                     input logic last, input logic [1:0] idx);
    return {3'b000, lr, ov, so, last, idx};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got {lr,ov,so,last,idx}=%h want %h", name, got, want);
    end
  endtask

  initial begin
    // lv ordy pin | lr ov so last idx
    vecs[0]  = mk(1, 1, F1,           1, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 1, 0,            0, 1, 8'h44, 0, 3);
    vecs[2]  = mk(0, 1, 0,            0, 1, 8'h33, 0, 2);
    vecs[3]  = mk(0, 1, 0,            0, 1, 8'h22, 0, 1);
    vecs[4]  = mk(0, 1, 0,            1, 1, 8'h11, 1, 0);
    vecs[5]  = mk(0, 1, 0,            1, 0, 8'h00, 0, 0);
    // backpressure on the first word
    vecs[6]  = mk(1, 0, F1,           1, 0, 8'h00, 0, 0);
    vecs[7]  = mk(0, 0, 0,            0, 1, 8'h44, 0, 3);
    vecs[8]  = mk(0, 0, 0,            0, 1, 8'h44, 0, 3);
    vecs[9]  = mk(0, 0, 0,            0, 1, 8'h44, 0, 3);
    vecs[10] = mk(0, 1, 0,            0, 1, 8'h44, 0, 3);
    vecs[11] = mk(0, 1, 0,            0, 1, 8'h33, 0, 2);
    vecs[12] = mk(0, 1, 0,            0, 1, 8'h22, 0, 1);
    vecs[13] = mk(0, 1, 0,            1, 1, 8'h11, 1, 0);
    vecs[14] = mk(0, 1, 0,            1, 0, 8'h00, 0, 0);
    // back-to-back frames, no bubble
    vecs[15] = mk(1, 1, F1,           1, 0, 8'h00, 0, 0);
    vecs[16] = mk(1, 1, F2,           0, 1, 8'h44, 0, 3);
    vecs[17] = mk(1, 1, F2,           0, 1, 8'h33, 0, 2);
    vecs[18] = mk(1, 1, F2,           0, 1, 8'h22, 0, 1);
    vecs[19] = mk(1, 1, F2,           1, 1, 8'h11, 1, 0);
    vecs[20] = mk(0, 1, 0,            0, 1, 8'hDD, 0, 3);
    vecs[21] = mk(0, 1, 0,            0, 1, 8'hCC, 0, 2);
    vecs[22] = mk(0, 1, 0,            0, 1, 8'hBB, 0, 1);
    vecs[23] = mk(0, 1, 0,            1, 1, 8'hAA, 1, 0);
    vecs[24] = mk(0, 1, 0,            1, 0, 8'h00, 0, 0);
    // parallel_in churns mid-frame
    vecs[25] = mk(1, 1, F1,           1, 0, 8'h00, 0, 0);
    vecs[26] = mk(1, 1, 32'hA5A5A5A5, 0, 1, 8'h44, 0, 3);
    vecs[27] = mk(1, 1, 32'h12345678, 0, 1, 8'h33, 0, 2);
    vecs[28] = mk(0, 1, 32'hFFFFFFFF, 0, 1, 8'h22, 0, 1);
    vecs[29] = mk(0, 1, 0,            1, 1, 8'h11, 1, 0);
    vecs[30] = mk(0, 1, 0,            1, 0, 8'h00, 0, 0);

    reset_n = 1'b0;
    a_lv = 1'b0; a_ordy = 1'b0; a_pin = '0;
    b_lv = 1'b0; b_ordy = 1'b0; b_pin = '0;
    #2;
    chk("reset_a", pk(a_lr, a_ov, a_so, a_last, a_idx), pk(0, 0, 8'h00, 0, 0));
    chk("reset_b", pk(b_lr, b_ov, b_so, b_last, b_idx), pk(0, 0, 8'h00, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      a_lv = vecs[i].lv; a_ordy = vecs[i].ordy; a_pin = vecs[i].pin;
      #1;
      chk($sformatf("vec%0d", i), pk(a_lr, a_ov, a_so, a_last, a_idx),
          pk(vecs[i].lr, vecs[i].ov, vecs[i].so, vecs[i].last, vecs[i].idx));
    end

    // Async reset after the second word aborts the frame.
    @(negedge clk);
    a_lv = 1'b1; a_pin = F1; a_ordy = 1'b1;
    #1 chk("rst_load", pk(a_lr, a_ov, a_so, a_last, a_idx), pk(1, 0, 8'h00, 0, 0));
    @(negedge clk);
    a_lv = 1'b0; a_pin = '0;
    #1 chk("rst_w1", pk(a_lr, a_ov, a_so, a_last, a_idx), pk(0, 1, 8'h44, 0, 3));
    @(negedge clk);
    #1 chk("rst_w2", pk(a_lr, a_ov, a_so, a_last, a_idx), pk(0, 1, 8'h33, 0, 2));
    #1 reset_n = 1'b0;
    #1 chk("rst_abort", pk(a_lr, a_ov, a_so, a_last, a_idx), pk(0, 0, 8'h00, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst_idle", pk(a_lr, a_ov, a_so, a_last, a_idx), pk(1, 0, 8'h00, 0, 0));
    @(negedge clk);
    #1 chk("rst_stay", pk(a_lr, a_ov, a_so, a_last, a_idx), pk(1, 0, 8'h00, 0, 0));

    // DEPTH=3, index order, with a stall on the last word.
    @(negedge clk);
    b_lv = 1'b1; b_pin = 24'h332211; b_ordy = 1'b1;
    #1 chk("b_load", pk(b_lr, b_ov, b_so, b_last, b_idx), pk(1, 0, 8'h00, 0, 0));
    @(negedge clk);
    b_lv = 1'b0; b_pin = '0;
    #1 chk("b_w0", pk(b_lr, b_ov, b_so, b_last, b_idx), pk(0, 1, 8'h11, 0, 0));
    @(negedge clk);
    #1 chk("b_w1", pk(b_lr, b_ov, b_so, b_last, b_idx), pk(0, 1, 8'h22, 0, 1));
    @(negedge clk);
    b_ordy = 1'b0;
    #1 chk("b_w2_stall", pk(b_lr, b_ov, b_so, b_last, b_idx), pk(0, 1, 8'h33, 1, 2));
    @(negedge clk);
    b_ordy = 1'b1;
    #1 chk("b_w2", pk(b_lr, b_ov, b_so, b_last, b_idx), pk(1, 1, 8'h33, 1, 2));
    @(negedge clk);
    #1 chk("b_idle", pk(b_lr, b_ov, b_so, b_last, b_idx), pk(1, 0, 8'h00, 0, 0));
    @(negedge clk);
    #1 chk("b_idle2", pk(b_lr, b_ov, b_so, b_last, b_idx), pk(1, 0, 8'h00, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
